// File: rtl/circuit1_pipe_if.sv
// -----------------------------------------------------------------------------
// circuit1_pipe_if
// Operand/result handshake bundle for circuit1_pipe.
//   in_valid/in_ready : operand triple (a, b, c) transfer
//   out_valid/out_ready : result (z, x, gt, eq) transfer
// Modports:
//   master : operand source / result sink side (drives operands, out_ready)
//   slave  : the datapath side (drives in_ready and results)
// -----------------------------------------------------------------------------
interface circuit1_pipe_if #(
  parameter int WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic [WIDTH-1:0]       c;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       z;
  logic [2*WIDTH-1:0]     x;
  logic                   gt;
  logic                   eq;

  modport master (
    output in_valid, a, b, c, out_ready,
    input  in_ready, out_valid, z, x, gt, eq
  );

  modport slave (
    input  in_valid, a, b, c, out_ready,
    output in_ready, out_valid, z, x, gt, eq
  );
endinterface

// File: rtl/circuit1_pipe.sv
// -----------------------------------------------------------------------------
// circuit1_pipe
// Two-stage valid/ready datapath. Per accepted triple (a, b, c):
//   d = a+b, e = a+c (mod 2^WIDTH), z = max(d, e), gt = d>e, eq = d==e,
//   x = a*c - d (mod 2^(2*WIDTH)). Signedness selected by SIGNED.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (clears all state immediately)
//   bus  : circuit1_pipe_if.slave (operand in, result out handshakes)
// Capacity is one token per stage; in_ready is combinational from out_ready.
// -----------------------------------------------------------------------------
module circuit1_pipe #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  circuit1_pipe_if.slave  bus
);
  localparam int W2 = 2 * WIDTH;

  // Stage 1 state
  logic              s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic [WIDTH-1:0]  e_q, e_d;
  logic [W2-1:0]     p_q, p_d;

  // Stage 2 state
  logic              s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]  z_q, z_d;
  logic [W2-1:0]     x_q, x_d;
  logic              gt_q, gt_d;
  logic              eq_q, eq_d;

  // Combinational helpers
  logic              adv1_s;
  logic              adv2_s;
  logic [W2-1:0]     a_ext_s;
  logic [W2-1:0]     c_ext_s;
  logic [W2-1:0]     d_ext_s;
  logic              gt_s;
  logic              eq_s;

  assign adv2_s = !s2_valid_q || bus.out_ready;
  assign adv1_s = !s1_valid_q || adv2_s;

  // Operand extension and stage-2 compare. Multiplying 2W-bit extended
  // operands and keeping the low 2W bits gives the exact signed or unsigned
  // product, so one multiplier serves both modes.
  always_comb begin
    if (SIGNED) begin
      a_ext_s = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
      c_ext_s = {{WIDTH{bus.c[WIDTH-1]}}, bus.c};
      d_ext_s = {{WIDTH{d_q[WIDTH-1]}}, d_q};
      gt_s    = ($signed(d_q) > $signed(e_q));
    end else begin
      a_ext_s = {{WIDTH{1'b0}}, bus.a};
      c_ext_s = {{WIDTH{1'b0}}, bus.c};
      d_ext_s = {{WIDTH{1'b0}}, d_q};
      gt_s    = (d_q > e_q);
    end
    eq_s = (d_q == e_q);
  end

  // Next-state for both stages; data loads only with a valid token so
  // bubbles leave held values untouched.
  always_comb begin
    s1_valid_d = s1_valid_q;
    d_d        = d_q;
    e_d        = e_q;
    p_d        = p_q;
    s2_valid_d = s2_valid_q;
    z_d        = z_q;
    x_d        = x_q;
    gt_d       = gt_q;
    eq_d       = eq_q;

    if (adv1_s) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        d_d = bus.a + bus.b;
        e_d = bus.a + bus.c;
        p_d = a_ext_s * c_ext_s;
      end else begin
        d_d = d_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (adv2_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        gt_d = gt_s;
        eq_d = eq_s;
        z_d  = gt_s ? d_q : e_q;
        x_d  = p_q - d_ext_s;
      end else begin
        z_d = z_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      d_q        <= '0;
      e_q        <= '0;
      p_q        <= '0;
      s2_valid_q <= 1'b0;
      z_q        <= '0;
      x_q        <= '0;
      gt_q       <= 1'b0;
      eq_q       <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      d_q        <= d_d;
      e_q        <= e_d;
      p_q        <= p_d;
      s2_valid_q <= s2_valid_d;
      z_q        <= z_d;
      x_q        <= x_d;
      gt_q       <= gt_d;
      eq_q       <= eq_d;
    end
  end

  assign bus.in_ready  = adv1_s;
  assign bus.out_valid = s2_valid_q;
  assign bus.z         = z_q;
  assign bus.x         = x_q;
  assign bus.gt        = gt_q;
  assign bus.eq        = eq_q;

endmodule

// File: tb/tb_circuit1_pipe.sv
module tb_circuit1_pipe;

  typedef struct packed {
    logic [7:0]  z;
    logic [15:0] x;
    logic        gt;
    logic        eq;
  } exp_t;

  logic clk;
  logic rst;

  circuit1_pipe_if #(.WIDTH(8)) bus_u ();
  circuit1_pipe_if #(.WIDTH(8)) bus_s ();

  circuit1_pipe #(.WIDTH(8), .SIGNED(1'b0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_u)
  );

  circuit1_pipe #(.WIDTH(8), .SIGNED(1'b1)) s_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t q_u[$];
  exp_t q_s[$];
  int   cmp_cnt = 0;
  int   err_cnt = 0;
  bit   xfer_u;
  bit   xfer_s;

  // Reference model: plain integer arithmetic, truncated to the output widths.
  function automatic exp_t model(logic [7:0] a, logic [7:0] b, logic [7:0] c, bit sgn);
    exp_t r;
    int av, bv, cv, dv, ev, xv;
    av = sgn ? int'($signed(a)) : int'(a);
    bv = sgn ? int'($signed(b)) : int'(b);
    cv = sgn ? int'($signed(c)) : int'(c);
    dv = (av + bv) & 255;
    ev = (av + cv) & 255;
    if (sgn && dv > 127) dv = dv - 256;
    if (sgn && ev > 127) ev = ev - 256;
    xv   = av * cv - dv;
    r.gt = (dv > ev);
    r.eq = (dv == ev);
    r.z  = r.gt ? dv[7:0] : ev[7:0];
    r.x  = xv[15:0];
    return r;
  endfunction

  // Called at the negedge after inputs are set: records transfers that the
  // coming posedge will perform, scoreboards outputs, then advances a cycle.
  task automatic step();
    exp_t e;
    #1;
    xfer_u = bus_u.in_valid && bus_u.in_ready;
    xfer_s = bus_s.in_valid && bus_s.in_ready;
    if (xfer_u) q_u.push_back(model(bus_u.a, bus_u.b, bus_u.c, 1'b0));
    if (xfer_s) q_s.push_back(model(bus_s.a, bus_s.b, bus_s.c, 1'b1));
    if (bus_u.out_valid && bus_u.out_ready) begin
      cmp_cnt++;
      if (q_u.size() == 0) begin
        err_cnt++;
        $display("FAIL sb_unsigned_extra: got z=%h x=%h with no result expected", bus_u.z, bus_u.x);
      end else begin
        e = q_u.pop_front();
        if ({bus_u.z, bus_u.x, bus_u.gt, bus_u.eq} !== e) begin
          err_cnt++;
          $display("FAIL sb_unsigned: got z=%h x=%h gt=%b eq=%b, want z=%h x=%h gt=%b eq=%b",
                   bus_u.z, bus_u.x, bus_u.gt, bus_u.eq, e.z, e.x, e.gt, e.eq);
        end
      end
    end
    if (bus_s.out_valid && bus_s.out_ready) begin
      cmp_cnt++;
      if (q_s.size() == 0) begin
        err_cnt++;
        $display("FAIL sb_signed_extra: got z=%h x=%h with no result expected", bus_s.z, bus_s.x);
      end else begin
        e = q_s.pop_front();
        if ({bus_s.z, bus_s.x, bus_s.gt, bus_s.eq} !== e) begin
          err_cnt++;
          $display("FAIL sb_signed: got z=%h x=%h gt=%b eq=%b, want z=%h x=%h gt=%b eq=%b",
                   bus_s.z, bus_s.x, bus_s.gt, bus_s.eq, e.z, e.x, e.gt, e.eq);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus_u.in_valid = 1'b0; bus_u.a = 8'd0; bus_u.b = 8'd0; bus_u.c = 8'd0;
    bus_u.out_ready = 1'b1;
    bus_s.in_valid = 1'b0; bus_s.a = 8'd0; bus_s.b = 8'd0; bus_s.c = 8'd0;
    bus_s.out_ready = 1'b1;
  endtask

  task automatic drain();
    int n;
    idle_inputs();
    n = 0;
    while ((q_u.size() != 0 || q_s.size() != 0) && n < 50) begin
      step();
      n++;
    end
    cmp_cnt++;
    if (q_u.size() != 0 || q_s.size() != 0) begin
      err_cnt++;
      $display("FAIL drain_timeout: pending unsigned=%0d signed=%0d, want 0/0", q_u.size(), q_s.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    cmp_cnt++;
    if ({bus_u.out_valid, bus_u.z, bus_u.x, bus_u.gt, bus_u.eq} !== 27'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got v=%b z=%h x=%h, want all 0", bus_u.out_valid, bus_u.z, bus_u.x);
    end
    cmp_cnt++;
    if (bus_u.in_ready !== 1'b1 || bus_s.in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_in_ready: got %b/%b, want 1/1", bus_u.in_ready, bus_s.in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    bus_u.a = 8'd10; bus_u.b = 8'd20; bus_u.c = 8'd5; bus_u.in_valid = 1'b1;
    step();
    bus_u.in_valid = 1'b0;
    cmp_cnt++;
    if (bus_u.out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL latency_early: out_valid=%b after one edge, want 0", bus_u.out_valid);
    end
    bus_u.out_ready = 1'b0;
    step();
    cmp_cnt++;
    if ({bus_u.out_valid, bus_u.z, bus_u.x, bus_u.gt, bus_u.eq} !== {1'b1, 8'd30, 16'd20, 1'b1, 1'b0}) begin
      err_cnt++;
      $display("FAIL latency_basic: got v=%b z=%0d x=%0d gt=%b eq=%b, want v=1 z=30 x=20 gt=1 eq=0",
               bus_u.out_valid, bus_u.z, bus_u.x, bus_u.gt, bus_u.eq);
    end
    drain();
  endtask

  task automatic test_vectors();
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic [7:0] vc [4];
    va = '{8'd10, 8'd200, 8'd7, 8'd1};
    vb = '{8'd20, 8'd100, 8'd3, 8'd5};
    vc = '{8'd5,  8'd3,   8'd3, 8'd1};
    for (int i = 0; i < 4; i++) begin
      bus_u.a = va[i]; bus_u.b = vb[i]; bus_u.c = vc[i]; bus_u.in_valid = 1'b1;
      step();
    end
    bus_u.in_valid = 1'b0;
    step();
    // Last vector (1,5,1) is now in stage 2 awaiting transfer.
    cmp_cnt++;
    if ({bus_u.out_valid, bus_u.z, bus_u.x, bus_u.gt} !== {1'b1, 8'd6, 16'hFFFB, 1'b1}) begin
      err_cnt++;
      $display("FAIL negative_x: got v=%b z=%0d x=%h gt=%b, want v=1 z=6 x=fffb gt=1",
               bus_u.out_valid, bus_u.z, bus_u.x, bus_u.gt);
    end
    drain();
  endtask

  task automatic test_signed();
    bus_s.a = 8'hFE; bus_s.b = 8'h01; bus_s.c = 8'h03; bus_s.in_valid = 1'b1;
    bus_s.out_ready = 1'b0;
    step();
    bus_s.in_valid = 1'b0;
    step();
    cmp_cnt++;
    if ({bus_s.out_valid, bus_s.z, bus_s.x, bus_s.gt, bus_s.eq} !== {1'b1, 8'h01, 16'hFFFB, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL signed_basic: got v=%b z=%h x=%h gt=%b eq=%b, want v=1 z=01 x=fffb gt=0 eq=0",
               bus_s.out_valid, bus_s.z, bus_s.x, bus_s.gt, bus_s.eq);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [7:0]  va [4];
    logic [7:0]  vb [4];
    logic [7:0]  vc [4];
    logic [7:0]  held_z;
    logic [15:0] held_x;
    bit          have_held;
    int          idx;
    int          n;
    va = '{8'd11, 8'd250, 8'd3, 8'd128};
    vb = '{8'd4,  8'd9,   8'd3, 8'd128};
    vc = '{8'd6,  8'd1,   8'd3, 8'd127};
    idx = 0;
    have_held = 1'b0;
    held_z = 8'd0;
    held_x = 16'd0;
    bus_u.out_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (idx < 4) begin
        bus_u.a = va[idx]; bus_u.b = vb[idx]; bus_u.c = vc[idx]; bus_u.in_valid = 1'b1;
      end else begin
        bus_u.in_valid = 1'b0;
      end
      step();
      if (xfer_u) idx++;
      if (bus_u.out_valid) begin
        if (have_held) begin
          cmp_cnt++;
          if (bus_u.z !== held_z || bus_u.x !== held_x) begin
            err_cnt++;
            $display("FAIL bp_stable: got z=%h x=%h, want held z=%h x=%h", bus_u.z, bus_u.x, held_z, held_x);
          end
        end else begin
          held_z = bus_u.z;
          held_x = bus_u.x;
          have_held = 1'b1;
        end
      end
    end
    #1;
    cmp_cnt++;
    if (idx != 2 || bus_u.in_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL bp_capacity: accepted=%0d in_ready=%b, want accepted=2 in_ready=0", idx, bus_u.in_ready);
    end
    @(negedge clk);
    bus_u.out_ready = 1'b1;
    n = 0;
    while (idx < 4 && n < 20) begin
      bus_u.a = va[idx]; bus_u.b = vb[idx]; bus_u.c = vc[idx]; bus_u.in_valid = 1'b1;
      step();
      if (xfer_u) idx++;
      n++;
    end
    cmp_cnt++;
    if (idx != 4) begin
      err_cnt++;
      $display("FAIL bp_accept_all: accepted=%0d, want 4", idx);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    bus_u.out_ready = 1'b0;
    bus_u.a = 8'd50; bus_u.b = 8'd60; bus_u.c = 8'd70; bus_u.in_valid = 1'b1;
    step();
    bus_u.a = 8'd33; bus_u.b = 8'd44; bus_u.c = 8'd55;
    step();
    bus_u.in_valid = 1'b0;
    #1;
    cmp_cnt++;
    if (bus_u.in_ready !== 1'b0 || bus_u.out_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL rm_full: in_ready=%b out_valid=%b, want 0/1", bus_u.in_ready, bus_u.out_valid);
    end
    #1 rst = 1'b1;
    #1;
    cmp_cnt++;
    if ({bus_u.out_valid, bus_u.z, bus_u.x, bus_u.gt, bus_u.eq, bus_u.in_ready} !== {27'd0, 1'b1}) begin
      err_cnt++;
      $display("FAIL rm_async_clear: got v=%b z=%h x=%h gt=%b eq=%b rdy=%b, want zeros rdy=1",
               bus_u.out_valid, bus_u.z, bus_u.x, bus_u.gt, bus_u.eq, bus_u.in_ready);
    end
    q_u.delete();
    q_s.delete();
    @(negedge clk);
    rst = 1'b0;
    bus_u.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      cmp_cnt++;
      if (bus_u.out_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL rm_stale: out_valid=%b after reset, want 0", bus_u.out_valid);
      end
    end
    bus_u.a = 8'd10; bus_u.b = 8'd20; bus_u.c = 8'd5; bus_u.in_valid = 1'b1;
    step();
    bus_u.in_valid = 1'b0;
    step();
    cmp_cnt++;
    if ({bus_u.out_valid, bus_u.z, bus_u.x} !== {1'b1, 8'd30, 16'd20}) begin
      err_cnt++;
      $display("FAIL rm_recover: got v=%b z=%0d x=%0d, want v=1 z=30 x=20", bus_u.out_valid, bus_u.z, bus_u.x);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      bus_u.in_valid  = ($urandom_range(3, 0) != 0);
      bus_u.out_ready = ($urandom_range(2, 0) != 0);
      bus_u.a = 8'($urandom_range(255, 0));
      bus_u.b = 8'($urandom_range(255, 0));
      bus_u.c = 8'($urandom_range(255, 0));
      bus_s.in_valid  = ($urandom_range(1, 0) != 0);
      bus_s.out_ready = ($urandom_range(3, 0) != 0);
      bus_s.a = 8'($urandom_range(255, 0));
      bus_s.b = 8'($urandom_range(255, 0));
      bus_s.c = 8'($urandom_range(255, 0));
      step();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_signed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/circuit1_pipe.md
# circuit1_pipe

Parametrised, pipelined successor of the single-cycle compare/select/multiply-subtract datapath. For each accepted operand triple (a, b, c) it computes d = a+b, e = a+c, z = max(d, e) with gt/eq flags, and x = a·c − d. Operation is unsigned or signed by parameter. A two-stage valid/ready pipeline sustains one result per cycle and holds results under backpressure. It sits between an operand source and a result sink in the scheduled-datapath test designs.

## Interface
- WIDTH, default 8: operand width; d, e, z are WIDTH bits; x is 2·WIDTH bits.
- SIGNED, default 0: 0 = unsigned arithmetic/compare; 1 = two's-complement arithmetic/compare.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand triple valid.
- in_ready  out  1  block can accept operands this cycle.
- a, b, c  in  WIDTH each  operands.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result this cycle.
- z  out  WIDTH  max(d, e).
- x  out  2·WIDTH  a·c − d.
- gt  out  1  d > e.
- eq  out  1  d == e.

## Operation
- Input transfer occurs when in_valid && in_ready at a rising edge. Output transfer occurs when out_valid && out_ready at a rising edge.
- Stage 1 registers, captured on input transfer:
  - d = (a+b) mod 2^WIDTH.
  - e = (a+c) mod 2^WIDTH.
  - p = a·c as a full 2·WIDTH product. It is signed if SIGNED=1, otherwise unsigned.
  - s1_valid.
- Stage 2 registers, computed from stage 1:
  - gt = (d > e) and eq = (d == e). The comparison is signed if SIGNED=1.
  - z = gt ? d : e.
  - x = (p − ext(d)) mod 2^(2·WIDTH). ext is sign-extension if SIGNED=1, zero-extension otherwise.
  - s2_valid drives out_valid.
- Flow control:
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1. in_ready is combinational from out_ready; there is no skid buffer.
- Stage 2 loads when adv2. Its new s2_valid = s1_valid.
- Stage 1 loads when adv1. Its new s1_valid = in_valid.
- Data registers load only when their stage loads with a valid token. They are otherwise held, so bubbles never disturb held data.
- While out_valid && !out_ready, z, x, gt, eq stay bit-stable.
- No overflow flags. All wrap is modular as defined above.
- Reset:
  - rst asserted at any time forces s1_valid, s2_valid, z, x, gt, eq, d, e, p to 0 immediately, without waiting for a clock edge.
  - In-flight tokens are discarded.
  - in_ready reads 1 during reset.
  - The first transfer is possible on the first rising edge after rst deasserts.

## Timing
- Latency: an operand transferred at edge k produces out_valid=1 after edge k+1. If out_ready stays high throughout, its output transfer occurs at edge k+2.
- Throughput: one triple per cycle when out_ready is continuously high.
- Capacity: two tokens, one per stage.
  - With out_ready low, in_ready falls once both stages are valid.
  - A streaming source is therefore stalled after two accepted triples.
- Same-cycle output transfer and input transfer with a full pipeline are legal and lose no token.
- in_valid may drop without a transfer. Operands are sampled only on transfer.

## Test plan
- WIDTH=8, SIGNED=0: a=10, b=20, c=5 -> out_valid two edges later with z=30, gt=1, eq=0, x=20.
- Wrap: a=200, b=100, c=3 -> d=44, e=203, z=203, gt=0, x=556 (0x022C).
- Equal and negative x:
  - a=7, b=3, c=3 -> z=10, eq=1, gt=0, x=11.
  - a=1, b=5, c=1 -> z=6, x=0xFFFB.
- SIGNED=1: a=0xFE (−2), b=1, c=3 -> d=0xFF, e=0x01, gt=0, z=0x01, x=0xFFFB (−5).
- Backpressure: stream 4 triples with out_ready=0 for 6 cycles, then 1.
  - Only 2 are accepted while out_ready=0; in_ready=0 after the second acceptance.
  - Held z/x stay stable while out_ready=0.
  - All 4 results emerge in order with no loss or duplication.
- Reset mid-stream: assert rst asynchronously, between edges, with both stages valid.
  - out_valid and all outputs go to 0 before the next edge.
  - After release, no stale result appears.
  - A new triple produces a correct result two edges after acceptance.
